// File: rtl/ext_pkg.sv
// Shared types and default sizing for the extinguisher head scheduler.
package ext_pkg;

    localparam int ZONES_DEF       = 8;
    localparam int POS_W_DEF       = 3;
    localparam int CONFIRM_CYC_DEF = 4;
    localparam int SPRAY_CYC_DEF   = 8;
    localparam int MAX_TRY_DEF     = 2;

    // One counter serves both the confirm window and the spray timer.
    localparam int CNT_W = $clog2((CONFIRM_CYC_DEF > SPRAY_CYC_DEF) ? CONFIRM_CYC_DEF : SPRAY_CYC_DEF);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONFIRM = 3'd1,
        ST_MOVE    = 3'd2,
        ST_SPRAY   = 3'd3,
        ST_CHECK   = 3'd4
    } state_t;

endpackage

// File: rtl/extinguisher_sched_rr_pick.sv
// Round-robin selector: first requesting zone strictly after `last`, wrapping to zone 0.
import ext_pkg::*;

module rr_pick #(
    parameter int ZONES = ZONES_DEF,
    parameter int POS_W = POS_W_DEF
) (
    input  logic [ZONES-1:0] req,
    input  logic [POS_W-1:0] last,
    output logic             valid,
    output logic [POS_W-1:0] idx
);

    logic [POS_W-1:0] w_zone;

    // Scan from the farthest offset down so the nearest requester after `last` wins.
    always_comb begin
        valid  = 1'b0;
        idx    = {POS_W{1'b0}};
        w_zone = {POS_W{1'b0}};
        for (int k = ZONES; k >= 1; k--) begin
            w_zone = POS_W'((int'(last) + k) % ZONES);
            if (req[w_zone]) begin
                valid = 1'b1;
                idx   = w_zone;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/extinguisher_sched.sv
// Single-head fire extinguisher sequencer: latches alarms, confirms, moves, sprays, re-checks.
import ext_pkg::*;

module extinguisher_sched #(
    parameter int ZONES       = ZONES_DEF,
    parameter int POS_W       = POS_W_DEF,
    parameter int CONFIRM_CYC = CONFIRM_CYC_DEF,
    parameter int SPRAY_CYC   = SPRAY_CYC_DEF,
    parameter int MAX_TRY     = MAX_TRY_DEF
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [ZONES-1:0] fire_in,
    output logic             ext_enable,
    output logic [POS_W-1:0] ext_pos,
    output logic             busy,
    output logic             done,
    output logic [ZONES-1:0] fault_mask
);

    localparam int CNT_MAX = (CONFIRM_CYC > SPRAY_CYC) ? CONFIRM_CYC : SPRAY_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int TW      = $clog2(MAX_TRY + 1);

    state_t           r_state;
    logic [ZONES-1:0] r_fire_q;
    logic [ZONES-1:0] r_pending;
    logic [ZONES-1:0] r_fault;
    logic [POS_W-1:0] r_last;
    logic [POS_W-1:0] r_target;
    logic [POS_W-1:0] r_pos;
    logic [CW-1:0]    r_cnt;
    logic [TW-1:0]    r_try;
    logic             r_en;
    logic             r_busy;
    logic             r_done;

    logic [ZONES-1:0] w_req;
    logic [ZONES-1:0] w_pend_clr;
    logic             w_valid;
    logic [POS_W-1:0] w_idx;
    logic [POS_W-1:0] w_step;
    logic             w_fire_tgt;
    logic             w_retry;

    assign w_req      = r_pending & ~r_fault;
    assign w_fire_tgt = r_fire_q[r_target];
    assign w_retry    = (int'(r_try) + 1) < MAX_TRY;

    assign ext_enable = r_en;
    assign ext_pos    = r_pos;
    assign busy       = r_busy;
    assign done       = r_done;
    assign fault_mask = r_fault;

    rr_pick #(
        .ZONES (ZONES),
        .POS_W (POS_W)
    ) u_pick (
        .req   (w_req),
        .last  (r_last),
        .valid (w_valid),
        .idx   (w_idx)
    );

    // Next head position one step toward the target.
    always_comb begin
        if (r_target > r_pos) begin
            w_step = r_pos + POS_W'(1);
        end else begin
            w_step = r_pos - POS_W'(1);
        end
    end

    // Pending clears on a false alarm or when CHECK releases the target (not on retry).
    always_comb begin
        w_pend_clr = {ZONES{1'b0}};
        if ((r_state == ST_CONFIRM && !w_fire_tgt) ||
            (r_state == ST_CHECK && !(w_fire_tgt && w_retry))) begin
            w_pend_clr[r_target] = 1'b1;
        end else begin
            w_pend_clr = {ZONES{1'b0}};
        end
    end

    // Sensor input register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_fire_q <= {ZONES{1'b0}};
        end else begin
            r_fire_q <= fire_in;
        end
    end

    // Alarm latch; a new sighting wins over a same-cycle clear.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_pending <= {ZONES{1'b0}};
        end else begin
            r_pending <= (r_pending & ~w_pend_clr) | (r_fire_q & ~r_fault);
        end
    end

    // Service FSM with registered outputs, counters and sticky fault flags.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state  <= ST_IDLE;
            r_last   <= POS_W'(ZONES - 1);
            r_target <= {POS_W{1'b0}};
            r_pos    <= {POS_W{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_try    <= {TW{1'b0}};
            r_en     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_fault  <= {ZONES{1'b0}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_target <= w_idx;
                        r_cnt    <= {CW{1'b0}};
                        r_busy   <= 1'b1;
                        r_state  <= ST_CONFIRM;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_CONFIRM: begin
                    if (!w_fire_tgt) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == CW'(CONFIRM_CYC - 1)) begin
                        r_cnt   <= {CW{1'b0}};
                        r_state <= ST_MOVE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_MOVE: begin
                    // Arrival is detected on the step that lands, so travel costs |distance| cycles.
                    if (r_pos == r_target || w_step == r_target) begin
                        r_pos   <= r_target;
                        r_cnt   <= {CW{1'b0}};
                        r_try   <= {TW{1'b0}};
                        r_en    <= 1'b1;
                        r_state <= ST_SPRAY;
                    end else begin
                        r_pos <= w_step;
                    end
                end
                ST_SPRAY: begin
                    if (r_cnt == CW'(SPRAY_CYC - 1)) begin
                        r_en    <= 1'b0;
                        r_state <= ST_CHECK;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_CHECK: begin
                    if (!w_fire_tgt) begin
                        r_last  <= r_target;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_retry) begin
                        r_try   <= r_try + TW'(1);
                        r_cnt   <= {CW{1'b0}};
                        r_en    <= 1'b1;
                        r_state <= ST_SPRAY;
                    end else begin
                        r_fault[r_target] <= 1'b1;
                        r_last            <= r_target;
                        r_busy            <= 1'b0;
                        r_state           <= ST_IDLE;
                    end
                end
                default: begin
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_extinguisher_sched.sv
// Self-checking bench: hand vectors, directed corner sequences and random stimulus vs a phase/timer model.
module tb_extinguisher_sched;

    localparam int NZ   = 8;
    localparam int CONF = 4;
    localparam int SPR  = 8;
    localparam int MTRY = 2;

    logic       clk;
    logic       clr_n;
    logic [7:0] fire_in;
    logic       ext_enable;
    logic [2:0] ext_pos;
    logic       busy;
    logic       done;
    logic [7:0] fault_mask;

    extinguisher_sched dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .fire_in    (fire_in),
        .ext_enable (ext_enable),
        .ext_pos    (ext_pos),
        .busy       (busy),
        .done       (done),
        .fault_mask (fault_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0 idle, 1 confirm, 2 travel, 3 spraying, 4 inspecting.
    int       ph;
    logic [7:0] mq, mpend, mfault;
    int       mlast, mtgt, mpos, mseen, mleft, mtries;
    bit       mdone;

    int       done_q[$];
    int       en_cycles, en_starts;
    bit       prev_en;

    task automatic model_reset();
        ph = 0; mq = 8'h00; mpend = 8'h00; mfault = 8'h00;
        mlast = NZ - 1; mtgt = 0; mpos = 0; mseen = 0; mleft = 0; mtries = 0;
        mdone = 1'b0; prev_en = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] fin);
        logic [7:0] clr;
        logic [7:0] nfault;
        int         nph;
        bit         found;
        clr = 8'h00; nfault = mfault; nph = ph; found = 1'b0;
        mdone = 1'b0;
        case (ph)
            0: begin
                for (int k = 1; k <= NZ; k++) begin
                    int z;
                    z = (mlast + k) % NZ;
                    if (!found && mpend[z] && !mfault[z]) begin
                        found = 1'b1; mtgt = z; mseen = 0; nph = 1;
                    end
                end
            end
            1: begin
                if (mq[mtgt]) begin
                    mseen++;
                    if (mseen == CONF) nph = 2;
                end else begin
                    clr[mtgt] = 1'b1; nph = 0;
                end
            end
            2: begin
                if (mpos != mtgt) mpos += (mtgt > mpos) ? 1 : -1;
                if (mpos == mtgt) begin
                    nph = 3; mleft = SPR; mtries = 1;
                end
            end
            3: begin
                mleft--;
                if (mleft == 0) nph = 4;
            end
            4: begin
                if (!mq[mtgt]) begin
                    clr[mtgt] = 1'b1; mlast = mtgt; mdone = 1'b1; nph = 0;
                end else if (mtries < MTRY) begin
                    mtries++; mleft = SPR; nph = 3;
                end else begin
                    nfault[mtgt] = 1'b1; clr[mtgt] = 1'b1; mlast = mtgt; nph = 0;
                end
            end
            default: nph = 0;
        endcase
        mpend  = (mpend & ~clr) | (mq & ~mfault);
        mfault = nfault;
        mq     = fin;
        ph     = nph;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One clock: model advances on the edge, outputs compared 1 time unit later.
    task automatic tick();
        logic [13:0] act, exp;
        @(posedge clk);
        model_step(fire_in);
        #1;
        act = {ext_enable, ext_pos, busy, done, fault_mask};
        exp = {(ph == 3), 3'(mpos), (ph != 0), mdone, mfault};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL model_cycle t=%0t actual en=%b pos=%0d busy=%b done=%b fm=%h required en=%b pos=%0d busy=%b done=%b fm=%h",
                     $time, act[13], act[12:10], act[9], act[8], act[7:0],
                     exp[13], exp[12:10], exp[9], exp[8], exp[7:0]);
        end
        if (done) done_q.push_back(int'(ext_pos));
        if (ext_enable) en_cycles++;
        if (ext_enable && !prev_en) en_starts++;
        prev_en = ext_enable;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #3 clr_n = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 clr_n = 1'b0;
        model_reset();
        @(posedge clk);
        release_reset();
    endtask

    task automatic wait_en(input string name, input int budget);
        int n;
        n = 0;
        while (!ext_enable && n < budget) begin
            tick(); n++;
        end
        chk({name, "_en_timeout"}, int'(ext_enable), 1);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick(); n++;
        end
        chk({name, "_done_timeout"}, int'(done), 1);
    endtask

    typedef struct {
        logic [7:0] fire;
        int         hold;
        logic       en;
        logic [2:0] pos;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[11];
    int   exp_order[4];
    int   path[$];

    initial begin
        // Zone 5 full service, then a 2-cycle blip on zone 3.
        vecs[0]  = '{8'h20, 3, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[1]  = '{8'h20, 4, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[2]  = '{8'h20, 5, 1'b1, 3'd5, 1'b1, 1'b0};
        vecs[3]  = '{8'h00, 3, 1'b1, 3'd5, 1'b1, 1'b0};
        vecs[4]  = '{8'h00, 5, 1'b0, 3'd5, 1'b1, 1'b0};
        vecs[5]  = '{8'h00, 1, 1'b0, 3'd5, 1'b0, 1'b1};
        vecs[6]  = '{8'h00, 1, 1'b0, 3'd5, 1'b0, 1'b0};
        vecs[7]  = '{8'h08, 2, 1'b0, 3'd5, 1'b0, 1'b0};
        vecs[8]  = '{8'h00, 1, 1'b0, 3'd5, 1'b1, 1'b0};
        vecs[9]  = '{8'h00, 1, 1'b0, 3'd5, 1'b0, 1'b0};
        vecs[10] = '{8'h00, 6, 1'b0, 3'd5, 1'b0, 1'b0};
        exp_order = '{1, 4, 6, 1};

        fire_in = 8'h00;
        clr_n   = 1'b1;
        model_reset();
        #3 clr_n = 1'b0;
        #4;
        chk("reset_outputs", int'({ext_enable, ext_pos, busy, done, fault_mask}), 0);
        release_reset();

        for (int i = 0; i < 11; i++) begin
            fire_in = vecs[i].fire;
            repeat (vecs[i].hold) tick();
            chk($sformatf("vec%0d_en", i),   int'(ext_enable), int'(vecs[i].en));
            chk($sformatf("vec%0d_pos", i),  int'(ext_pos),    int'(vecs[i].pos));
            chk($sformatf("vec%0d_busy", i), int'(busy),       int'(vecs[i].busy));
            chk($sformatf("vec%0d_done", i), int'(done),       int'(vecs[i].done));
        end

        // Zones 1, 4, 6 together from reset; zone 1 re-raised during zone 6 service.
        do_reset();
        done_q.delete();
        fire_in = 8'h52;
        for (int s = 0; s < 4; s++) begin
            wait_en("rr", 60);
            if (s == 2) fire_in[1] = 1'b1;
            fire_in[ext_pos] = 1'b0;
            wait_done("rr", 40);
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_order%0d", i), (i < done_q.size()) ? done_q[i] : -1, exp_order[i]);

        // Zone 2 never goes out: two sprays, then a sticky fault.
        done_q.delete();
        en_cycles = 0; en_starts = 0;
        fire_in = 8'h04;
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 80; n++) begin
                tick();
                if (busy) seen = 1'b1;
                else if (seen) break;
            end
        end
        chk("fault_idle", int'(busy), 0);
        chk("fault_en_cycles", en_cycles, 2 * SPR);
        chk("fault_en_bursts", en_starts, 2);
        chk("fault_mask", int'(fault_mask), 8'h04);
        chk("fault_no_done", done_q.size(), 0);
        begin
            int bc;
            bc = 0;
            repeat (30) begin
                tick();
                if (busy) bc++;
            end
            chk("fault_ignored", bc, 0);
        end
        fire_in = 8'h00;

        // Park head at 6, then travel down to zone 1.
        fire_in = 8'h40;
        wait_en("park", 60);
        chk("park_pos", int'(ext_pos), 6);
        fire_in = 8'h00;
        wait_done("park", 40);
        fire_in = 8'h02;
        path.delete();
        path.push_back(int'(ext_pos));
        for (int n = 0; n < 40 && !ext_enable; n++) begin
            tick();
            if (int'(ext_pos) != path[$]) path.push_back(int'(ext_pos));
        end
        for (int i = 0; i < 6; i++)
            chk($sformatf("path%0d", i), (i < path.size()) ? path[i] : -1, 6 - i);
        fire_in = 8'h00;
        wait_done("path", 40);

        // Reset in the middle of a spray drops outputs without a clock edge.
        fire_in = 8'h20;
        wait_en("midrst", 60);
        #2 clr_n = 1'b0;
        #1;
        chk("midrst_en", int'(ext_enable), 0);
        chk("midrst_pos", int'(ext_pos), 0);
        chk("midrst_busy", int'(busy), 0);
        model_reset();
        release_reset();
        wait_en("relatch", 60);
        chk("relatch_pos", int'(ext_pos), 5);
        fire_in = 8'h00;
        wait_done("relatch", 40);

        // Random sensor activity against the model.
        for (int seg = 0; seg < 2; seg++) begin
            do_reset();
            fire_in = 8'h00;
            for (int c = 0; c < 2500; c++) begin
                if ($urandom_range(0, 11) == 0) begin
                    int b;
                    b = int'($urandom_range(0, 7));
                    fire_in[b] = ~fire_in[b];
                end
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
